timer_preempcao_param: RTL and testbench
========================================

Name: timer_preempcao_param

Overview:
- Parametrised preemptive-scheduling timer for the multiprogrammed CPU.
- Counts clock cycles while a user program runs in user address space (pcAtual >= KERNEL_LIMIT). Raises interrupt request `timer` when the programmable quantum expires.
- Supports off, one-shot and periodic modes, a runtime-loadable quantum, an explicit interrupt-acknowledge handshake, and a saturating preemption counter.
- Sits between the PC/control unit and the interrupt logic that vectors to the kernel scheduler.

Parameters:
- DATA_WIDTH, 32, width of prog, preempcao, pcAtual.
- CNT_WIDTH, 16, width of quantum register and cycle counter.
- QUANTUM_DEFAULT, 80, quantum loaded at reset (cycles).
- KERNEL_LIMIT, 3000, first user-space address; pcAtual below this is kernel.
- NPREEMP_WIDTH, 8, width of the saturating preemption counter.

Ports:
- clock_auto  in  1  system clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- prog  in  DATA_WIDTH  current program id; 0 = no user program.
- preempcao  in  DATA_WIDTH  mode: 0 off, 1 one-shot, 2 periodic, other values = off.
- pcAtual  in  DATA_WIDTH  current PC.
- quantum_load  in  1  load quantum_valor into the quantum register.
- quantum_valor  in  CNT_WIDTH  new quantum in cycles.
- irq_ack  in  1  interrupt acknowledge from the interrupt logic.
- timer  out  1  preemption interrupt request (level).
- expirado  out  1  one-cycle pulse on quantum expiry.
- contagem  out  CNT_WIDTH  current cycle count.
- num_preempcoes  out  NPREEMP_WIDTH  total expiries, saturating.

Behaviour:
- Reset (async, reset_n=0): state OCIOSO, contagem=0, timer=0, expirado=0, num_preempcoes=0, quantum_reg=QUANTUM_DEFAULT.
- Enable condition: ativo = (prog!=0) && (preempcao==1 || preempcao==2) && (pcAtual >= KERNEL_LIMIT), evaluated combinationally each cycle.
- Kernel condition: kernel = pcAtual < KERNEL_LIMIT.
- All state changes occur on the rising edge of clock_auto. expirado defaults to 0 every cycle.
- States: OCIOSO, CONTANDO, PENDENTE, DESARMADO.
- Priority each cycle, highest first:
  1. ~ativo: state OCIOSO, contagem=0. timer cleared only if kernel. Holds in PENDENTE if ~kernel (prog/mode dropped while pending keeps the request until ack).
  2. quantum_load.
  3. irq_ack.
  4. counting.
- OCIOSO: if ativo -> CONTANDO, contagem=0.
- CONTANDO: if contagem == quantum_reg-1 -> timer=1, expirado=1, contagem=0, num_preempcoes+=1 (saturate at all-ones), -> PENDENTE. Else contagem+=1.
- Timing: with ativo continuously high, timer rises exactly quantum_reg+1 edges after ativo first seen (1 edge to enter CONTANDO, quantum_reg edges counting).
- PENDENTE: timer held at 1, contagem held at 0.
  - irq_ack -> timer=0; mode 2 -> CONTANDO; mode 1 -> DESARMADO.
  - kernel entry -> timer=0, OCIOSO.
- DESARMADO: no counting, timer=0. Leaves to OCIOSO only when ~ativo.
- irq_ack outside PENDENTE is ignored.
- quantum_load: quantum_reg = (quantum_valor==0) ? 1 : quantum_valor. In CONTANDO also restarts contagem=0 and suppresses an expiry that would occur in the same cycle. Allowed in any state.
- No wrap: contagem < quantum_reg <= 2^CNT_WIDTH-1 at all times.
- Mode change 1<->2 while CONTANDO does not restart the count; it only affects the post-ack transition.
- reset_n asserted mid-count or while PENDENTE: immediate return to reset values, no pulse.

Test Plan:
- Reset, prog=5, preempcao=2, pcAtual=4000 held -> timer rises 81 edges after reset release, expirado one pulse, num_preempcoes=1; irq_ack -> timer=0 next edge, second expiry 80 edges later, num_preempcoes=2.
- Mode 1, same stimulus -> one expiry; after irq_ack state DESARMADO, no further timer; pcAtual=100 then 4000 -> re-arms, expires after 81 edges.
- While PENDENTE, drive pcAtual=2999 -> timer=0 next edge, contagem=0; pcAtual=3000 -> counting resumes (boundary is user space).
- quantum_load with quantum_valor=5 at contagem=40 -> contagem=0, expiry 5 edges later; quantum_valor=0 -> expiry every cycle after each ack (quantum 1).
- quantum_load in the same cycle as contagem==quantum_reg-1 -> no expirado, contagem=0; irq_ack in CONTANDO ignored.
- NPREEMP_WIDTH=2, 5 expiries -> num_preempcoes saturates at 3; reset_n pulse while timer=1 -> timer=0 asynchronously, all counters 0.

Source files
------------

// File: rtl/timer_preempcao_param.sv
// Preemptive-scheduling timer: counts user-space cycles and requests a
// scheduler interrupt when the programmable quantum expires.
module timer_preempcao_param #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter int unsigned QUANTUM_DEFAULT = 80,
  parameter int unsigned KERNEL_LIMIT    = 3000,
  parameter int unsigned NPREEMP_WIDTH   = 8
) (
  input  logic                     clock_auto,
  input  logic                     reset_n,
  input  logic [DATA_WIDTH-1:0]    prog,
  input  logic [DATA_WIDTH-1:0]    preempcao,
  input  logic [DATA_WIDTH-1:0]    pcAtual,
  input  logic                     quantum_load,
  input  logic [CNT_WIDTH-1:0]     quantum_valor,
  input  logic                     irq_ack,
  output logic                     timer,
  output logic                     expirado,
  output logic [CNT_WIDTH-1:0]     contagem,
  output logic [NPREEMP_WIDTH-1:0] num_preempcoes
);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    CONTANDO  = 2'd1,
    PENDENTE  = 2'd2,
    DESARMADO = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_WIDTH-1:0]     contagem_q, contagem_d;
  logic [CNT_WIDTH-1:0]     quantum_q, quantum_d;
  logic                     timer_q, timer_d;
  logic                     expirado_q, expirado_d;
  logic [NPREEMP_WIDTH-1:0] npre_q, npre_d;

  logic                     ativo;
  logic                     kernel;
  logic                     modo_valido;
  logic                     modo_periodico;
  logic [CNT_WIDTH-1:0]     quantum_novo;

  // Qualifiers derived from the current inputs.
  always_comb begin
    kernel         = pcAtual < DATA_WIDTH'(KERNEL_LIMIT);
    modo_periodico = preempcao == DATA_WIDTH'(2);
    modo_valido    = (preempcao == DATA_WIDTH'(1)) || modo_periodico;
    ativo          = (prog != '0) && modo_valido && !kernel;
    quantum_novo   = (quantum_valor == '0) ? CNT_WIDTH'(1) : quantum_valor;
  end

  // Next-state and output logic, priority: inactive, quantum load, ack, count.
  always_comb begin
    state_d    = state_q;
    contagem_d = contagem_q;
    timer_d    = timer_q;
    expirado_d = 1'b0;
    npre_d     = npre_q;
    quantum_d  = quantum_load ? quantum_novo : quantum_q;

    if (!ativo) begin
      contagem_d = '0;
      if ((state_q == PENDENTE) && !kernel) begin
        // Request survives a dropped program/mode until acknowledged.
        if (irq_ack) begin
          timer_d = 1'b0;
          state_d = OCIOSO;
        end
      end else begin
        timer_d = 1'b0;
        state_d = OCIOSO;
      end
    end else if (quantum_load && (state_q == CONTANDO)) begin
      // Restart with the new quantum; any same-cycle expiry is dropped.
      contagem_d = '0;
    end else begin
      case (state_q)
        OCIOSO: begin
          state_d    = CONTANDO;
          contagem_d = '0;
        end
        CONTANDO: begin
          if (contagem_q == (quantum_q - CNT_WIDTH'(1))) begin
            timer_d    = 1'b1;
            expirado_d = 1'b1;
            contagem_d = '0;
            state_d    = PENDENTE;
            if (npre_q != '1) begin
              npre_d = npre_q + NPREEMP_WIDTH'(1);
            end
          end else begin
            contagem_d = contagem_q + CNT_WIDTH'(1);
          end
        end
        PENDENTE: begin
          if (irq_ack) begin
            timer_d    = 1'b0;
            contagem_d = '0;
            state_d    = modo_periodico ? CONTANDO : DESARMADO;
          end
        end
        DESARMADO: begin
          timer_d = 1'b0;
        end
        default: begin
          state_d = OCIOSO;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock_auto or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= OCIOSO;
      contagem_q <= '0;
      quantum_q  <= CNT_WIDTH'(QUANTUM_DEFAULT);
      timer_q    <= 1'b0;
      expirado_q <= 1'b0;
      npre_q     <= '0;
    end else begin
      state_q    <= state_d;
      contagem_q <= contagem_d;
      quantum_q  <= quantum_d;
      timer_q    <= timer_d;
      expirado_q <= expirado_d;
      npre_q     <= npre_d;
    end
  end

  assign timer          = timer_q;
  assign expirado       = expirado_q;
  assign contagem       = contagem_q;
  assign num_preempcoes = npre_q;

endmodule

// File: tb/tb_timer_preempcao_param.sv
// Scoreboard bench for timer_preempcao_param: directed scenarios followed by
// randomized traffic, all checked against a behavioural reference model.
module tb_timer_preempcao_param;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned QD = 80;
  localparam int unsigned KL = 3000;
  localparam int unsigned NW = 3;
  localparam int unsigned NMAX = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] prog = '0;
  logic [DW-1:0] mode = '0;
  logic [DW-1:0] pc = '0;
  logic          qload = 1'b0;
  logic [CW-1:0] qv = '0;
  logic          ack = 1'b0;
  logic          timer;
  logic          expirado;
  logic [CW-1:0] contagem;
  logic [NW-1:0] npre;

  timer_preempcao_param #(
    .DATA_WIDTH(DW), .CNT_WIDTH(CW), .QUANTUM_DEFAULT(QD),
    .KERNEL_LIMIT(KL), .NPREEMP_WIDTH(NW)
  ) dut (
    .clock_auto(clk), .reset_n(rst_n), .prog(prog), .preempcao(mode),
    .pcAtual(pc), .quantum_load(qload), .quantum_valor(qv), .irq_ack(ack),
    .timer(timer), .expirado(expirado), .contagem(contagem),
    .num_preempcoes(npre)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          timer;
    bit          expirado;
    int unsigned cnt;
    int unsigned npre;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: a task is "armed" (counting), "raised" (request out),
  // "spent" (one-shot done) or none of these (idle).
  bit          m_armed, m_raised, m_spent, m_pulse;
  int unsigned m_elapsed, m_quantum, m_total;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_raised = 0; m_spent = 0; m_pulse = 0;
    m_elapsed = 0; m_quantum = QD; m_total = 0;
  endtask

  task automatic model_step();
    bit          user, running;
    int unsigned new_q;
    user    = pc >= KL;
    running = (prog != 0) && (mode == 1 || mode == 2) && user;
    new_q   = qload ? ((qv == 0) ? 1 : int'(qv)) : m_quantum;
    m_pulse = 0;
    if (!running) begin
      m_elapsed = 0;
      if (m_raised && user) begin
        if (ack) m_raised = 0;
      end else begin
        m_armed = 0; m_raised = 0; m_spent = 0;
      end
    end else if (m_armed && qload) begin
      m_elapsed = 0;
    end else if (m_raised) begin
      if (ack) begin
        m_raised  = 0;
        m_elapsed = 0;
        if (mode == 2) m_armed = 1; else m_spent = 1;
      end
    end else if (m_spent) begin
      // one-shot already consumed: wait for the task to leave
    end else if (!m_armed) begin
      m_armed   = 1;
      m_elapsed = 0;
    end else if (m_elapsed + 1 == m_quantum) begin
      m_armed   = 0;
      m_raised  = 1;
      m_pulse   = 1;
      m_elapsed = 0;
      if (m_total < NMAX) m_total++;
    end else begin
      m_elapsed++;
    end
    m_quantum = new_q;
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.timer    = m_raised;
    e.expirado = m_pulse;
    e.cnt      = m_elapsed;
    e.npre     = m_total;
    return e;
  endfunction

  // One clock of stimulus: drive after the edge, predict the next edge.
  task automatic step(input int unsigned p, input int unsigned md, input int unsigned pcv,
                      input bit ld, input int unsigned q, input bit ak);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    prog  = DW'(p);
    mode  = DW'(md);
    pc    = DW'(pcv);
    qload = ld;
    qv    = CW'(q);
    ack   = ak;
    model_step();
    sbq.push_back(snapshot());
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    qload = 1'b0;
    ack   = 1'b0;
    model_reset();
    #1;
    chk("async_rst_timer", 32'(timer), 32'(0));
    chk("async_rst_exp", 32'(expirado), 32'(0));
    chk("async_rst_cnt", 32'(contagem), 32'(0));
    chk("async_rst_npre", 32'(npre), 32'(0));
    sbq.push_back(snapshot());
  endtask

  task automatic run(input int n, input int unsigned md, input int unsigned pcv);
    for (int i = 0; i < n; i++) step(5, md, pcv, 0, 0, 0);
  endtask

  // Monitor: every edge the DUT presents a new output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("timer", 32'(timer), 32'(e.timer));
        chk("expirado", 32'(expirado), 32'(e.expirado));
        chk("contagem", 32'(contagem), e.cnt);
        chk("num_preempcoes", 32'(npre), e.npre);
      end
    end
  end

  initial begin
    int unsigned r, p, md, pcv, q;
    bit ld, ak;
    model_reset();
    do_reset();

    // Periodic: first expiry 81 edges after release, second 80 after ack.
    run(85, 2, 4000);
    step(5, 2, 4000, 0, 0, 1);
    run(82, 2, 4000);
    // One-shot: ack disarms, kernel visit re-arms.
    step(5, 1, 4000, 0, 0, 1);
    run(20, 1, 4000);
    run(2, 1, 100);
    run(85, 1, 4000);
    // Kernel entry while pending, then the boundary address is user space.
    run(1, 2, 2999);
    run(40, 2, 3000);
    // Shorten quantum mid-count.
    step(5, 2, 3000, 1, 5, 0);
    run(7, 2, 3000);
    // Quantum 0 means 1: expiry every cycle after each ack; counter saturates.
    step(5, 2, 3000, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(5, 2, 3000, 0, 0, 1);
      step(5, 2, 3000, 0, 0, 0);
    end
    // Load coinciding with the expiry cycle suppresses it; ack while counting ignored.
    step(5, 2, 3000, 1, 5, 0);
    step(5, 2, 3000, 0, 0, 1);
    run(4, 2, 3000);
    step(5, 2, 3000, 1, 5, 0);
    step(5, 2, 3000, 0, 0, 1);
    step(5, 2, 3000, 0, 0, 1);
    run(6, 2, 3000);
    // Reset while the request is raised.
    do_reset();
    run(3, 2, 4000);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        continue;
      end
      r = $urandom_range(0, 99);
      pcv = (r < 4) ? 100 : (r < 7) ? 2999 : (r < 10) ? 3000 : (r < 12) ? $urandom : 4000;
      r = $urandom_range(0, 99);
      p = (r < 2) ? 0 : (r < 4) ? $urandom : 5;
      r = $urandom_range(0, 99);
      md = (r < 3) ? $urandom_range(0, 7) : (r < 15) ? 1 : 2;
      ld = $urandom_range(0, 99) < 4;
      q  = ($urandom_range(0, 99) < 25) ? 0 : $urandom_range(1, 20);
      ak = $urandom_range(0, 99) < 25;
      step(p, md, pcv, ld, q, ak);
    end

    repeat (2) @(posedge clk);
    #3;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
